// File: rtl/encoder_8to3_seq_if.sv
// rtl/encoder_8to3_seq_if.sv - handshake bundle for encoder_8to3_seq (optional count under ENC_COUNT_OUT_EN)
interface encoder_8to3_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] y;
  logic       last;
  logic       zero_err;
`ifdef ENC_COUNT_OUT_EN
  logic [3:0] count;
`endif

  // Producer/consumer side: drives the request vector and the output-accept.
  modport master (
    output in_valid,
    output d,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  last,
`ifdef ENC_COUNT_OUT_EN
    input  count,
`endif
    input  zero_err
  );

  // Encoder side.
  modport slave (
    input  in_valid,
    input  d,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output last,
`ifdef ENC_COUNT_OUT_EN
    output count,
`endif
    output zero_err
  );
endinterface

// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - sequential 8-to-3 priority encoder emitting every set bit once (optional count under ENC_COUNT_OUT_EN)
module encoder_8to3_seq #(
  parameter int LSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  encoder_8to3_seq_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       zero_err_q, zero_err_d;

  logic [2:0] sel_idx;
  logic       sel_last;

  // Index of the bit to service next: highest set bit, or lowest when LSB_FIRST.
  function automatic logic [2:0] pick_idx(input logic [7:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (p[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (p[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_single(input logic [7:0] p);
    return (p != 8'd0) && ((p & (p - 8'd1)) == 8'd0);
  endfunction

  // Selection derived purely from the pending register so outputs stay Moore.
  always_comb begin
    sel_idx  = pick_idx(pend_q);
    sel_last = is_single(pend_q);
  end

  // State, pending vector and zero-vector flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 8'd0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_err_q <= zero_err_d;
    end
  end

  // Next-state: capture in IDLE, retire one bit per accepted beat in EMIT.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.d != 8'd0) begin
            pend_d  = bus.d;
            state_d = EMIT;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pend_d = pend_q & ~(8'd1 << sel_idx);
          if (sel_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 8'd0;
      end
    endcase
  end

  // Outputs decoded from registered state; zeroed whenever not emitting.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == EMIT);
    bus.y         = (state_q == EMIT) ? sel_idx : 3'd0;
    bus.last      = (state_q == EMIT) ? sel_last : 1'b0;
    bus.zero_err  = zero_err_q;
  end

`ifdef ENC_COUNT_OUT_EN
  // Remaining bit count, reported only while emitting.
  always_comb begin
    bus.count = 4'd0;
    if (state_q == EMIT) begin
      for (int i = 0; i < 8; i++) begin
        bus.count = bus.count + {3'd0, pend_q[i]};
      end
    end
  end
`endif

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - scoreboard bench for encoder_8to3_seq, MSB-first and LSB-first instances
module tb_encoder_8to3_seq;

  typedef struct {
    logic [2:0] y;
    logic       last;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  encoder_8to3_seq_if if0 ();
  encoder_8to3_seq_if if1 ();

  encoder_8to3_seq #(.LSB_FIRST(0)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(if0));
  encoder_8to3_seq #(.LSB_FIRST(1)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(if1));

  exp_t q0[$];
  exp_t q1[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  logic zpend  = 1'b0;

  logic       stalled [2];
  logic [2:0] held_y  [2];
  logic       held_l  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: list the set bits in service order with remaining-count and last flag.
  task automatic model_push(input logic [7:0] v);
    int k;
    int j;
    k = $countones(v);
    j = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        q0.push_back('{y: 3'(i), last: (j == k - 1), cnt: 4'(k - j)});
        j++;
      end
    end
    j = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        q1.push_back('{y: 3'(i), last: (j == k - 1), cnt: 4'(k - j)});
        j++;
      end
    end
  endtask

  // Advance one cycle and check the zero-vector pulse predicted last cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("zero_err_msb", int'(if0.zero_err), int'(zpend));
    chk("zero_err_lsb", int'(if1.zero_err), int'(zpend));
    zpend = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [7:0] dv, input logic ordy);
    if0.in_valid = iv;  if1.in_valid = iv;
    if0.d        = dv;  if1.d        = dv;
    if0.out_ready = ordy; if1.out_ready = ordy;
    if (iv && if0.in_ready) begin
      if (dv == 8'd0) zpend = 1'b1;
      else model_push(dv);
    end
  endtask

  task automatic check_out(input int i, input logic ov, input logic ordy, input logic ir,
                           input logic [2:0] yv, input logic lv, input logic [3:0] cv);
    exp_t e;
    chk($sformatf("in_ready_vs_valid%0d", i), int'(ir), int'(!ov));
    if (ov) begin
      if (stalled[i]) begin
        chk($sformatf("stall_y%0d", i), int'(yv), int'(held_y[i]));
        chk($sformatf("stall_last%0d", i), int'(lv), int'(held_l[i]));
      end
      if (ordy) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          n_chk++;
          $display("FAIL unexpected_beat%0d: got y=%0d expected no output at %0t", i, yv, $time);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("y%0d", i), int'(yv), int'(e.y));
          chk($sformatf("last%0d", i), int'(lv), int'(e.last));
`ifdef ENC_COUNT_OUT_EN
          chk($sformatf("count%0d", i), int'(cv), int'(e.cnt));
`else
          if (cv != 4'd0) begin
            n_chk++;
            $display("FAIL count_stub%0d: got %0d expected 0", i, cv);
          end
`endif
        end
      end
    end
    stalled[i] = ov && !ordy;
    held_y[i]  = yv;
    held_l[i]  = lv;
  endtask

  // Monitor: compare every accepted beat against the scoreboard, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] c0;
    logic [3:0] c1;
`ifdef ENC_COUNT_OUT_EN
    c0 = if0.count;
    c1 = if1.count;
`else
    c0 = 4'd0;
    c1 = 4'd0;
`endif
    if (!rst_n) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      check_out(0, if0.out_valid, if0.out_ready, if0.in_ready, if0.y, if0.last, c0);
      check_out(1, if1.out_valid, if1.out_ready, if1.in_ready, if1.y, if1.last, c1);
    end
  end

  // Accept one vector with out_ready high and check the k+1 cycle occupancy.
  task automatic run_vec(input logic [7:0] v);
    int k;
    k = $countones(v);
    tick();
    drive(1'b1, v, 1'b1);
    for (int j = 0; j < k; j++) begin
      tick();
      chk("busy_valid_msb", int'(if0.out_valid), 1);
      chk("busy_valid_lsb", int'(if1.out_valid), 1);
      drive(1'b0, 8'd0, 1'b1);
    end
    tick();
    chk("done_in_ready", int'(if0.in_ready), 1);
    chk("done_valid", int'(if0.out_valid), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, int'(if0.out_valid | if1.out_valid), 0);
    chk({tag, "_y"}, int'(if0.y | if1.y), 0);
    chk({tag, "_last"}, int'(if0.last | if1.last), 0);
    chk({tag, "_in_ready"}, int'(if0.in_ready & if1.in_ready), 1);
    chk({tag, "_zero_err"}, int'(if0.zero_err | if1.zero_err), 0);
`ifdef ENC_COUNT_OUT_EN
    chk({tag, "_count"}, int'(if0.count | if1.count), 0);
`endif
  endtask

  initial begin
    logic [7:0] v;
    logic       iv;
    logic       ordy;
    int         sel;
    logic [7:0] toggles;

    rst_n = 1'b0;
    stalled[0] = 1'b0;
    stalled[1] = 1'b0;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    if0.d = 8'd0;        if1.d = 8'd0;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // Single bit, then all bits, with continuous out_ready.
    run_vec(8'b0000_1000);
    run_vec(8'hFF);

    // Stalls: out_ready toggles 1,0,1,0,1 during a three-bit vector.
    tick();
    drive(1'b1, 8'b1010_0001, 1'b0);
    toggles = 8'b0001_0101;
    for (int j = 0; j < 5; j++) begin
      tick();
      drive(1'b0, 8'd0, toggles[j]);
    end
    tick();
    drive(1'b0, 8'd0, 1'b1);
    tick();
    chk("stall_done_in_ready", int'(if0.in_ready), 1);

    // All-zero vector: one-cycle zero_err, no output.
    drive(1'b1, 8'h00, 1'b1);
    tick();
    chk("zero_valid", int'(if0.out_valid), 0);
    chk("zero_in_ready", int'(if0.in_ready), 1);
    drive(1'b0, 8'd0, 1'b1);
    tick();

    // Reset mid-vector; in_valid held with 8'h01 while emitting must be ignored.
    drive(1'b1, 8'hF0, 1'b1);
    tick();
    drive(1'b1, 8'h01, 1'b1);
    tick();
    drive(1'b0, 8'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    q0.delete();
    q1.delete();
    zpend = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("post_reset_valid", int'(if0.out_valid | if1.out_valid), 0);
      drive(1'b0, 8'd0, 1'b1);
    end

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      tick();
      sel  = int'($urandom_range(0, 7));
      v    = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(iv, v, ordy);
    end

    // Drain.
    tick();
    drive(1'b0, 8'd0, 1'b1);
    for (int n = 0; n < 12; n++) begin
      tick();
      drive(1'b0, 8'd0, 1'b1);
    end
    chk("drain_q_msb", q0.size(), 0);
    chk("drain_q_lsb", q1.size(), 0);
    chk("drain_idle", int'(if0.in_ready & if1.in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
